// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared types and constants for the fetch-to-decode queue
// Contents:
//   VEC_W         width of the fetch-side exception vector
//   IFQ_NOP_WORD  instruction word shown at the head while the queue is empty
//   ifq_entry_t   one queue entry {inst, pc, pc_4, vector}, 101 bits
//   ENTRY_W       packed width of ifq_entry_t
//   ifq_idle_entry() head value presented while empty (NOP word, all else 0)
package if_id_queue_pkg;

    localparam int          VEC_W        = 5;
    localparam logic [31:0] IFQ_NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]      inst;
        logic [31:0]      pc;
        logic [31:0]      pc_4;
        logic [VEC_W-1:0] vector;
    } ifq_entry_t;

    localparam int ENTRY_W = $bits(ifq_entry_t);

    function automatic ifq_entry_t ifq_idle_entry(input logic [31:0] nop_word);
        ifq_entry_t e;
        e      = '0;
        e.inst = nop_word;
        return e;
    endfunction

endpackage

// File: rtl/ifq_storage.sv
// rtl/ifq_storage.sv - DEPTH x ENTRY_W register array, one write port, one async read port
// Ports:
//   i_clk     clock, rising edge
//   i_we      write enable
//   i_waddr   write address (PTR_W bits)
//   i_wdata   entry to write
//   i_raddr   read address (PTR_W bits)
//   o_rdata   entry at i_raddr, combinational
// Contents are not reset; the owner masks reads while the queue is empty.
module ifq_storage
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  ifq_entry_t       i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output ifq_entry_t       o_rdata
);

    ifq_entry_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - instruction fetch queue between fetch and decode
// Optional feature macro: IFQ_BYPASS_EN (empty-queue fall-through to the head outputs)
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   if_valid   fetch offers an entry
//   if_ready   queue can accept an entry (drives fetch pc_write)
//   pc_if      PC of fetched word
//   pc_4_if    PC+4 of fetched word
//   inst_if    fetched instruction word
//   vector_if  fetch-side exception vector, 0 = none
//   id_valid   head entry valid
//   id_ready   decode consumes the head entry
//   inst_id    head instruction, NOP_WORD when empty
//   pc_id      head PC, 0 when empty
//   pc_4_id    head PC+4, 0 when empty
//   vector_id  head vector, 0 when empty
//   flush      redirect: drop every queued entry at the next edge
//   count      occupancy, 0..DEPTH
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter int          PTR_W    = 1,
    parameter logic [31:0] NOP_WORD = IFQ_NOP_WORD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      pc_if,
    input  logic [31:0]      pc_4_if,
    input  logic [31:0]      inst_if,
    input  logic [VEC_W-1:0] vector_if,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      inst_id,
    output logic [31:0]      pc_id,
    output logic [31:0]      pc_4_id,
    output logic [VEC_W-1:0] vector_id,
    input  logic             flush,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic       w_full;
    logic       w_empty;
    logic       w_bypass;
    logic       w_push;
    logic       w_pop;
    ifq_entry_t w_wr_entry;
    ifq_entry_t w_rd_entry;
    ifq_entry_t w_head;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    assign w_wr_entry.inst   = inst_if;
    assign w_wr_entry.pc     = pc_if;
    assign w_wr_entry.pc_4   = pc_4_if;
    assign w_wr_entry.vector = vector_if;

`ifdef IFQ_BYPASS_EN
    // An incoming entry on an empty queue is shown at the head in the same
    // cycle. If decode takes it right away it never touches storage.
    assign w_bypass = w_empty & if_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // if_ready looks only at registered occupancy so decode stalls never
    // reach fetch combinationally.
    assign if_ready = ~w_full;

    assign w_push = if_valid & ~w_full & ~flush & ~(w_bypass & id_ready);
    assign w_pop  = ~w_empty & id_ready & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // pointers wrap through natural PTR_W overflow (DEPTH is 2**PTR_W)
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_comb begin
        w_head = ifq_idle_entry(NOP_WORD);
        if (w_bypass) begin
            w_head = w_wr_entry;
        end else if (!w_empty) begin
            w_head = w_rd_entry;
        end
    end

    assign id_valid  = ~w_empty | w_bypass;
    assign inst_id   = w_head.inst;
    assign pc_id     = w_head.pc;
    assign pc_4_id   = w_head.pc_4;
    assign vector_id = w_head.vector;
    assign count     = r_count;

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(w_push && w_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(w_pop && w_empty));
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue (DEPTH=2)
module tb_if_id_queue;
    import if_id_queue_pkg::*;

`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        if_valid  = 1'b0;
    logic        id_ready  = 1'b0;
    logic        flush     = 1'b0;
    logic [31:0] pc_if     = '0;
    logic [31:0] pc_4_if   = '0;
    logic [31:0] inst_if   = '0;
    logic [4:0]  vector_if = '0;

    logic        if_ready;
    logic        id_valid;
    logic [31:0] inst_id;
    logic [31:0] pc_id;
    logic [31:0] pc_4_id;
    logic [4:0]  vector_id;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;
    ifq_entry_t exp_q[$];

    if_id_queue #(.DEPTH(2), .PTR_W(1), .NOP_WORD(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .pc_if     (pc_if),
        .pc_4_if   (pc_4_if),
        .inst_if   (inst_if),
        .vector_if (vector_if),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .inst_id   (inst_id),
        .pc_id     (pc_id),
        .pc_4_id   (pc_4_id),
        .vector_id (vector_id),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: 1ns before each rising edge, any entry decode is taking is
    // compared against the oldest expected entry.
    always @(negedge clk) begin
        ifq_entry_t e;
        #4;
        if (!reset && id_valid && id_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc %0h expected no entry", pc_id);
            end else begin
                e = exp_q.pop_front();
                chk("pop_entry", {27'd0, inst_id, pc_id, pc_4_id, vector_id}, {27'd0, e});
            end
        end
    end

    task automatic step(input logic v, input logic r, input logic f,
                        input logic [31:0] pc, input logic [4:0] vec,
                        input logic [31:0] pc4, input logic [31:0] inst,
                        input bit exp_push);
        ifq_entry_t e;
        @(negedge clk);
        if_valid  = v;
        id_ready  = r;
        flush     = f;
        pc_if     = pc;
        pc_4_if   = pc4;
        inst_if   = inst;
        vector_if = vec;
        if (exp_push) begin
            e.inst   = inst;
            e.pc     = pc;
            e.pc_4   = pc4;
            e.vector = vec;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (f) exp_q.delete();
    endtask

    task automatic push_pc(input logic [31:0] pc, input logic r);
        step(1'b1, r, 1'b0, pc, 5'd0, pc + 32'd4, 32'hC000_0000 | pc, 1'b1);
    endtask

    task automatic idle(input logic r);
        step(1'b0, r, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifq_entry_t e;
        // reset between edges takes effect immediately
        #3 reset = 1'b1;
        #1;
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_inst_id",  inst_id,  32'h0);
        chk("rst_pc_id",    pc_id,    32'h0);
        chk("rst_if_ready", if_ready, 1'b1);
        chk("rst_count",    count,    2'd0);
        @(negedge clk);
        reset = 1'b0;

        // fill
        push_pc(32'h10, 1'b0);
        chk("fill1_count", count, 2'd1);
        chk("fill1_pc_id", pc_id, 32'h10);
        push_pc(32'h14, 1'b0);
        chk("fill2_count",    count,    2'd2);
        chk("fill2_if_ready", if_ready, 1'b0);

        // drain one (0x10), then push 0x18 while popping 0x14
        idle(1'b1);
        chk("drain1_count", count, 2'd1);
        push_pc(32'h18, 1'b1);
        chk("pp_count", count, 2'd1);
        chk("pp_pc_id", pc_id, 32'h18);

        // back-to-back push+pop across pointer wrap
        for (int k = 0; k < 6; k++) begin
            push_pc(32'h100 + 32'(4 * k), 1'b1);
            chk("b2b_count", count, 2'd1);
        end
        chk("b2b_pc_id", pc_id, 32'h114);

        // fill to 2, then flush together with push and pop
        push_pc(32'h120, 1'b0);
        chk("full_count", count, 2'd2);
        step(1'b1, 1'b1, 1'b1, 32'h1C, 5'd0, 32'h20, 32'hC000_001C, 1'b0);
        chk("flush_count",    count,    2'd0);
        chk("flush_id_valid", id_valid, 1'b0);
        chk("flush_if_ready", if_ready, 1'b1);

        push_pc(32'h40, 1'b0);
        chk("vec_addr_pc_id", pc_id, 32'h40);
        idle(1'b1);
        chk("vec_addr_drain", count, 2'd0);

        // exception vector and pc_4 carried unchanged
        step(1'b1, 1'b0, 1'b0, 32'hA000_0100, 5'd3, 32'hA000_0104, 32'h2000_0000, 1'b1);
        chk("carry_vector",  vector_id,     5'd3);
        chk("carry_pc4_top", pc_4_id[31:28], 4'hA);
        chk("carry_inst",    inst_id,       32'h2000_0000);
        idle(1'b1);

        // empty queue, valid and ready together
        @(negedge clk);
        if_valid = 1'b1; id_ready = 1'b1; flush = 1'b0;
        pc_if = 32'h20; pc_4_if = 32'h24; inst_if = 32'hC000_0020; vector_if = 5'd0;
        e.inst = 32'hC000_0020; e.pc = 32'h20; e.pc_4 = 32'h24; e.vector = 5'd0;
        exp_q.push_back(e);
        #2;
        chk("byp_same_pc", pc_id,    BYP ? 32'h20 : 32'h0);
        chk("byp_same_v",  id_valid, BYP);
        @(posedge clk);
        #1;
        chk("byp_count", count, BYP ? 2'd0 : 2'd1);
        idle(1'b1);
        chk("byp_drain", count, 2'd0);

        // asynchronous reset mid-operation
        push_pc(32'h80, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count",    count,    2'd0);
        chk("mid_rst_id_valid", id_valid, 1'b0);
        chk("mid_rst_pc_id",    pc_id,    32'h0);
        exp_q.delete();
        @(negedge clk);
        if_valid = 1'b0;
        reset    = 1'b0;
        idle(1'b0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
